// File: rtl/sdpram_stream_reader_if.sv
// Valid/ready word stream carrying data read out of the SDPRAM.
// The reader drives the master side and the downstream consumer drives the slave side.
interface sdpram_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sdpram_stream_reader.sv
// Read engine for the single-clock SDPRAM: issues BASE..BASE+LEN-1 (mod DEPTH) and streams
// the returned words through a credit-limited buffer sized to hide the RAM read latency.
module sdpram_stream_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 128,
  parameter int ADDR_WIDTH  = (DEPTH >= 2) ? $clog2(DEPTH) : 1,
  parameter int RAM_LATENCY = 2,
  parameter int LEN_WIDTH   = ADDR_WIDTH + 1
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  START_I,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR_I,
  input  logic [LEN_WIDTH-1:0]  LEN_I,
  output logic                  BUSY_O,
  output logic                  DONE_O,
  output logic [ADDR_WIDTH-1:0] RADDR_O,
  output logic                  REN_O,
  input  logic [DATA_WIDTH-1:0] RDATA_I,
  sdpram_stream_reader_if.master m_if
);

  localparam int BUF_DEPTH = RAM_LATENCY + 2;
  localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t                  state_q,      state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q,      raddr_d;
  logic                    ren_q,        ren_d;
  logic [LEN_WIDTH-1:0]    issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]    beat_left_q,  beat_left_d;
  logic [CNT_WIDTH-1:0]    used_q,       used_d;
  logic [RAM_LATENCY-1:0]  tag_q,        tag_d;
  logic [DATA_WIDTH-1:0]   buf_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]   buf_d [BUF_DEPTH];
  logic [CNT_WIDTH-1:0]    cnt_q,        cnt_d;
  logic                    valid_q,      valid_d;
  logic                    busy_q,       busy_d;
  logic                    done_q,       done_d;

  logic                    pop_s;
  logic                    push_s;
  logic [CNT_WIDTH-1:0]    used_after_pop_s;
  logic                    credit_ok_s;
  logic [ADDR_WIDTH-1:0]   raddr_next_s;
  logic [CNT_WIDTH-1:0]    wr_idx_s;
  logic [RAM_LATENCY:0]    tag_shift_s;

  assign pop_s            = valid_q & m_if.ready;
  assign push_s           = tag_q[RAM_LATENCY-1];
  // used_q counts reads issued (including the one on REN_O now) plus words held in the buffer
  assign used_after_pop_s = used_q - (pop_s ? CNT_ONE : {CNT_WIDTH{1'b0}});
  assign credit_ok_s      = (used_after_pop_s < CNT_FULL);
  assign raddr_next_s     = (raddr_q == ADDR_LAST) ? {ADDR_WIDTH{1'b0}} : (raddr_q + ADDR_ONE);
  assign tag_shift_s      = {tag_q, ren_q};
  assign wr_idx_s         = cnt_q - (pop_s ? CNT_ONE : {CNT_WIDTH{1'b0}});

  // Transfer FSM: read issue, beat counting and status outputs
  always_comb begin
    state_d      = state_q;
    raddr_d      = raddr_q;
    ren_d        = 1'b0;
    issue_left_d = issue_left_q;
    if (pop_s) begin
      beat_left_d = beat_left_q - LEN_ONE;
    end else begin
      beat_left_d = beat_left_q;
    end
    case (state_q)
      S_IDLE: begin
        if (START_I && (LEN_I == LEN_ZERO)) begin
          state_d = S_FIN;
        end else if (START_I) begin
          state_d      = S_ISSUE;
          ren_d        = 1'b1;
          raddr_d      = BASE_ADDR_I;
          issue_left_d = LEN_I - LEN_ONE;
          beat_left_d  = LEN_I;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_left_q == LEN_ZERO) begin
          state_d = S_DRAIN;
        end else if (credit_ok_s) begin
          ren_d        = 1'b1;
          raddr_d      = raddr_next_s;
          issue_left_d = issue_left_q - LEN_ONE;
          state_d      = (issue_left_q == LEN_ONE) ? S_DRAIN : S_ISSUE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (pop_s && (beat_left_q == LEN_ONE)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    used_d = used_after_pop_s + (ren_d ? CNT_ONE : {CNT_WIDTH{1'b0}});
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    tag_d  = tag_shift_s[RAM_LATENCY-1:0];
  end

  // Output buffer: shift towards the head on pop, write the returning word behind the survivors
  always_comb begin
    buf_d = buf_q;
    if (pop_s) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        buf_d[i] = buf_q[i+1];
      end
    end else begin
      buf_d[0] = buf_q[0];
    end
    if (push_s) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (CNT_WIDTH'(i) == wr_idx_s) begin
          buf_d[i] = RDATA_I;
        end else begin
          buf_d[i] = buf_d[i];
        end
      end
      cnt_d = wr_idx_s + CNT_ONE;
    end else begin
      cnt_d = wr_idx_s;
    end
    valid_d = (cnt_d != {CNT_WIDTH{1'b0}});
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q      <= S_IDLE;
      raddr_q      <= {ADDR_WIDTH{1'b0}};
      ren_q        <= 1'b0;
      issue_left_q <= LEN_ZERO;
      beat_left_q  <= LEN_ZERO;
      used_q       <= {CNT_WIDTH{1'b0}};
      tag_q        <= {RAM_LATENCY{1'b0}};
      cnt_q        <= {CNT_WIDTH{1'b0}};
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      raddr_q      <= raddr_d;
      ren_q        <= ren_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      used_q       <= used_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign BUSY_O     = busy_q;
  assign DONE_O     = done_q;
  assign RADDR_O    = raddr_q;
  assign REN_O      = ren_q;
  assign m_if.data  = buf_q[0];
  assign m_if.valid = valid_q;

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Scoreboard bench: three reader instances (DEPTH 128/lat 2, DEPTH 100/lat 2, DEPTH 128/lat 1),
// each with an SDPRAM model preloaded so RAM[a] = a.
module tb_sdpram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [3];
  logic [6:0] base_v  [3];
  logic [7:0] len_v   [3];
  logic       ready_v [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic       ren_a   [3];
  logic       valid_a [3];
  logic [6:0] raddr_a [3];
  logic [7:0] data_a  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gch
    localparam int DEP = (g == 1) ? 100 : 128;
    localparam int LAT = (g == 2) ? 1 : 2;
    logic [7:0] mem [DEP];
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] rdata;

    sdpram_stream_reader_if #(.DATA_WIDTH(8)) sif ();

    initial begin
      for (int a = 0; a < DEP; a++) mem[a] = 8'(a);
    end

    always_ff @(posedge clk) begin
      if (ren_a[g]) r1 <= mem[raddr_a[g]];
      r2 <= r1;
    end
    assign rdata      = (LAT == 1) ? r1 : r2;
    assign sif.ready  = ready_v[g];
    assign data_a[g]  = sif.data;
    assign valid_a[g] = sif.valid;

    sdpram_stream_reader #(
      .DATA_WIDTH (8),
      .DEPTH      (DEP),
      .RAM_LATENCY(LAT)
    ) dut (
      .CLK_I      (clk),
      .RST_I      (rst),
      .START_I    (start_v[g]),
      .BASE_ADDR_I(base_v[g]),
      .LEN_I      (len_v[g]),
      .BUSY_O     (busy_a[g]),
      .DONE_O     (done_a[g]),
      .RADDR_O    (raddr_a[g]),
      .REN_O      (ren_a[g]),
      .RDATA_I    (rdata),
      .m_if       (sif)
    );
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc_n    = 0;
  int         ch       = 0;
  logic [7:0] exp_d [$];
  logic [6:0] exp_a [$];
  int         ren_cnt, beat_cnt, done_cnt, first_beat, last_beat, done_cyc;
  logic       busy_at_done, prev_valid, prev_ready;
  logic [7:0] prev_data;
  bit         rnd_ready = 1'b0;
  bit         chk_addr  = 1'b0;

  function automatic int lat_of(input int c);
    return (c == 2) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_counters();
    ren_cnt = 0; beat_cnt = 0; done_cnt = 0;
    first_beat = 0; last_beat = 0; done_cyc = 0;
    busy_at_done = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = 8'd0;
    exp_d.delete();
    exp_a.delete();
  endtask

  // One clock: choose READY, then observe the selected channel and score it
  task automatic do_cycle();
    @(negedge clk);
    cyc_n++;
    if (rnd_ready) ready_v[ch] = 1'($urandom_range(0, 1));
    else           ready_v[ch] = 1'b1;
    if (ren_a[ch]) begin
      ren_cnt++;
      if (chk_addr) begin
        check("raddr_expected", 32'(exp_a.size() > 0), 32'd1);
        if (exp_a.size() > 0) check("raddr", 32'(raddr_a[ch]), 32'(exp_a.pop_front()));
      end
    end
    check("credit_bound", 32'((ren_cnt - beat_cnt) <= (lat_of(ch) + 2)), 32'd1);
    if (prev_valid && !prev_ready) begin
      check("hold_valid", 32'(valid_a[ch]), 32'd1);
      check("hold_data", 32'(data_a[ch]), 32'(prev_data));
    end
    if (valid_a[ch] && ready_v[ch]) begin
      if (beat_cnt == 0) first_beat = cyc_n;
      last_beat = cyc_n;
      beat_cnt++;
      check("beat_expected", 32'(exp_d.size() > 0), 32'd1);
      if (exp_d.size() > 0) check("data", 32'(data_a[ch]), 32'(exp_d.pop_front()));
    end
    if (done_a[ch]) begin
      done_cnt++;
      done_cyc     = cyc_n;
      busy_at_done = busy_a[ch];
    end
    prev_valid = valid_a[ch];
    prev_ready = ready_v[ch];
    prev_data  = data_a[ch];
  endtask

  task automatic xfer(input int c, input int b, input int l, input bit rnd,
                      input bit addr_chk, input bit extra);
    int t0;
    int dep;
    dep       = (c == 1) ? 100 : 128;
    ch        = c;
    rnd_ready = rnd;
    chk_addr  = addr_chk;
    clear_counters();
    for (int i = 0; i < l; i++) begin
      exp_d.push_back(8'((b + i) % dep));
      if (addr_chk) exp_a.push_back(7'((b + i) % dep));
    end
    start_v[c] = 1'b1;
    base_v[c]  = 7'(b);
    len_v[c]   = 8'(l);
    t0         = cyc_n;
    do_cycle();
    start_v[c] = 1'b0;
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      if (extra && k == 2) begin
        start_v[c] = 1'b1;
        base_v[c]  = 7'd50;
        len_v[c]   = 8'd3;
      end else begin
        start_v[c] = 1'b0;
      end
      do_cycle();
    end
    start_v[c] = 1'b0;
    repeat (4) do_cycle();
    check("done_count", 32'(done_cnt), 32'd1);
    check("beat_count", 32'(beat_cnt), 32'(l));
    check("ren_count", 32'(ren_cnt), 32'(l));
    check("beats_missing", 32'(exp_d.size()), 32'd0);
    if (!rnd && l > 0) begin
      check("first_beat_latency", 32'(first_beat - t0), 32'(lat_of(c) + 2));
      check("full_rate", 32'(last_beat - first_beat), 32'(l - 1));
      check("done_after_last", 32'(done_cyc - last_beat), 32'd1);
    end else if (l == 0) begin
      check("len0_done_cycle", 32'(done_cyc - t0), 32'd1);
      check("len0_busy", 32'(busy_at_done), 32'd1);
    end
    exp_a.delete();
  endtask

  initial begin
    int t0;
    for (int c = 0; c < 3; c++) begin
      start_v[c] = 1'b0; base_v[c] = 7'd0; len_v[c] = 8'd0; ready_v[c] = 1'b1;
    end
    rst = 1'b1;
    clear_counters();
    repeat (3) do_cycle();
    rst = 1'b0;
    do_cycle();
    for (int c = 0; c < 3; c++) begin
      check("rst_busy",  32'(busy_a[c]),  32'd0);
      check("rst_done",  32'(done_a[c]),  32'd0);
      check("rst_ren",   32'(ren_a[c]),   32'd0);
      check("rst_raddr", 32'(raddr_a[c]), 32'd0);
      check("rst_valid", 32'(valid_a[c]), 32'd0);
      check("rst_data",  32'(data_a[c]),  32'd0);
    end

    xfer(0, 10, 4, 1'b0, 1'b1, 1'b1);
    xfer(0, 126, 4, 1'b0, 1'b1, 1'b0);
    xfer(1, 98, 4, 1'b0, 1'b1, 1'b0);
    xfer(0, 0, 20, 1'b1, 1'b0, 1'b0);
    xfer(0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Abort a LEN=10 transfer with a one-cycle reset right after the third beat
    ch = 0; rnd_ready = 1'b0; chk_addr = 1'b0;
    clear_counters();
    for (int i = 0; i < 10; i++) exp_d.push_back(8'(i));
    start_v[0] = 1'b1; base_v[0] = 7'd0; len_v[0] = 8'd10;
    t0 = cyc_n;
    do_cycle();
    start_v[0] = 1'b0;
    for (int k = 0; k < 50 && beat_cnt < 3; k++) do_cycle();
    check("abort_reach_beat3", 32'(beat_cnt), 32'd3);
    check("abort_beat3_cycle", 32'(last_beat - t0), 32'd6);
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    check("abort_valid", 32'(valid_a[0]), 32'd0);
    check("abort_ren", 32'(ren_a[0]), 32'd0);
    check("abort_busy", 32'(busy_a[0]), 32'd0);
    exp_d.delete();
    repeat (12) do_cycle();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_beats", 32'(beat_cnt), 32'd3);
    xfer(0, 5, 2, 1'b0, 1'b1, 1'b0);

    xfer(2, 10, 4, 1'b0, 1'b1, 1'b0);
    xfer(2, 0, 20, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
